spi_master_engine: RTL and testbench
====================================

// Module: spi_master_engine
// PURPOSE
//   SPI initiator (mode 0, CPOL=0/CPHA=0) that drives SCLK/CS_n/MOSI and samples MISO.
//   It is the opposite end of the bridge's SPI capture slave: it consumes the same
//   {rw, addr, data} command word the write FIFO carries and serialises it onto the link.
//   For reads, it returns the byte captured from MISO on a response handshake.
//   It sits between the command/response FIFOs (PCLK domain) and the SPI pins.
// PARAMETERS
//   WIDTH    8  address and data field width; frame length is 2*WIDTH+1 bits
//   CLK_DIV  4  PCLK cycles per SCLK half-period; legal range is >=1
// PORTS
//   PCLK       in   1          sole clock; all logic is on the rising edge
//   reset      in   1          asynchronous, active-high reset
//   cmd_valid  in   1          command word valid
//   cmd_ready  out  1          engine can accept a command
//   cmd_data   in   2*WIDTH+1  [2W]=rw (1 write, 0 read); [2W-1:W]=addr; [W-1:0]=wdata
//   rsp_valid  out  1          read data valid (reads only)
//   rsp_ready  in   1          response accepted
//   rsp_data   out  WIDTH      byte captured from MISO
//   busy       out  1          high in every state except IDLE
//   SCLK       out  1          serial clock, idle low
//   CS_n       out  1          chip select, active low
//   MOSI       out  1          serial data out, MSB first
//   MISO       in   1          serial data in
// BEHAVIOUR
//   Reset values: SCLK=0, CS_n=1, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0.
//     In the first cycle after reset, state is IDLE and cmd_ready=1.
//   Handshake rules:
//     A transfer occurs when valid&&ready in the same cycle.
//     cmd_ready is high only in IDLE, and is a registered function of state.
//     cmd_data is ignored whenever cmd_ready=0.
//   FSM states: IDLE -> SHIFT -> HOLD -> GAP -> (RESP if read) -> IDLE.
//   IDLE: on cmd accept at cycle T, latch the word into a shift register.
//     At T+1: CS_n=0, MOSI=bit[2W], enter SHIFT.
//   SHIFT: runs for 2W+1 bits, each 2*CLK_DIV cycles long.
//     First CLK_DIV cycles: SCLK=0, MOSI stable.
//     Last CLK_DIV cycles: SCLK=1.
//     MISO is sampled on the PCLK edge where SCLK goes 0->1.
//     MOSI advances to the next bit on the edge where SCLK goes 1->0.
//     The bit counter runs 2W down to 0. After the high half of bit 0, SCLK=0 and the FSM enters HOLD.
//   HOLD: CLK_DIV cycles with CS_n=0 and SCLK=0, then CS_n=1 and the FSM enters GAP.
//   GAP: CLK_DIV cycles with CS_n=1 (minimum deselect time).
//     A read raises rsp_valid on GAP entry.
//   Read data: rsp_data = the last WIDTH MISO samples, MSB first.
//     MISO samples taken during rw/addr bits are discarded.
//     Writes never raise rsp_valid.
//   RESP: reached only if GAP ends while rsp_valid is still high. The FSM waits there.
//     rsp_valid and rsp_data are held stable until rsp_ready.
//     The FSM returns to IDLE in the cycle after the handshake.
//     A read handshake during GAP clears rsp_valid; the FSM then goes GAP -> IDLE directly.
//   Frame length, CS_n low to CS_n high: (2W+1)*2*CLK_DIV + CLK_DIV cycles.
//     The next CS_n fall is at least CLK_DIV+1 cycles later.
//   Simultaneous events:
//     cmd_valid during a frame is held off (no accept, no side effect).
//     rsp_ready with rsp_valid=0 has no effect.
//   Reset mid-frame: all outputs return immediately (asynchronously) to their reset values.
//     CS_n=1 terminates the frame. The partial frame is dropped and no response is generated.
//   Divider: the counter reloads on every state or half-period change.
//     With CLK_DIV=1, SCLK = PCLK/2.
// STRUCTURE
//   Package spi_bridge_pkg holds:
//     - state enum spi_state_t {IDLE, SHIFT, HOLD, GAP, RESP}
//     - frame field offsets RW_BIT, ADDR_MSB/LSB, DATA_MSB/LSB
//     - FRAME_BITS = 2*WIDTH+1
//     These are shared with the capture slave and the APB front end.
//   Sub-module spi_clk_div: half-period counter with load/enable.
//     Outputs a one-cycle `half_tick` every CLK_DIV cycles.
//   The FSM, shift registers and bit counter stay in this module.
// TESTING
//   Run all cases with CLK_DIV=2, WIDTH=8.
//   1. Write: cmd_data=17'h1_A5_3C.
//      -> MOSI on the 17 SCLK rises = 1,10100101,00111100.
//      -> CS_n low for 70 cycles; rsp_valid never rises.
//   2. Read: cmd_data=17'h0_12_00, with the model slave driving 0xC3 on the last 8 bits.
//      -> rsp_valid=1 at GAP entry, rsp_data=8'hC3.
//      -> MOSI = 0,00010010,00000000.
//   3. Backpressure: read with rsp_ready=0 for 20 cycles.
//      -> FSM holds in RESP; rsp_data is stable; cmd_ready=0.
//      -> On rsp_ready=1, cmd_ready=1 one cycle later.
//   4. Back-to-back: two writes with cmd_valid held high.
//      -> Second accepted exactly 3 cycles after CS_n rises (CLK_DIV gap + 1).
//      -> The first accept drops cmd_ready for the full frame.
//   5. Reset mid-frame: assert reset at bit 7 of SHIFT.
//      -> Same cycle: CS_n=1, SCLK=0, MOSI=0.
//      -> After release: IDLE, cmd_ready=1, no rsp_valid.
//   6. CLK_DIV=1: run the scenario 1 frame.
//      -> SCLK period is 2 PCLK cycles; CS_n low for 35 cycles; bits identical to scenario 1.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared SPI bridge definitions: FSM state encoding and the {rw, addr, data} frame layout.
// Used by the SPI master engine, the capture slave and the APB front end.
package spi_bridge_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT, HOLD, GAP, RESP} spi_state_t;

  localparam int WIDTH_DEF  = 8;
  localparam int FRAME_BITS = 2*WIDTH_DEF + 1;
  localparam int RW_BIT     = 2*WIDTH_DEF;
  localparam int ADDR_MSB   = 2*WIDTH_DEF - 1;
  localparam int ADDR_LSB   = WIDTH_DEF;
  localparam int DATA_MSB   = WIDTH_DEF - 1;
  localparam int DATA_LSB   = 0;

  function automatic int frame_bits(input int width);
    return 2*width + 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: emits a one-cycle tick every CLK_DIV enabled cycles.
// Reloads on i_load or on its own tick, so every half-period and state starts fresh.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic PCLK,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_half_tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_half_tick = i_en && (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_cnt <= RELOAD;
    end else if (i_load || o_half_tick) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 initiator: serialises {rw, addr, wdata} MSB first and returns the
// last WIDTH MISO samples of a read frame through a valid/ready response port.
module spi_master_engine
  import spi_bridge_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             PCLK,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2*WIDTH:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             SCLK,
  output logic             CS_n,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int N_BITS = frame_bits(WIDTH);
  localparam int BCW    = $clog2(N_BITS);

  spi_state_t        r_state, w_next;
  logic [N_BITS-1:0] r_tx;
  logic [WIDTH-1:0]  r_rx;
  logic [BCW-1:0]    r_bit_cnt;
  logic              r_rw;
  logic              r_sclk;
  logic              r_cs_n;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_data;

  logic w_accept, w_rsp_hs, w_half_tick, w_div_load, w_div_en;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_rsp_hs = r_rsp_valid && rsp_ready;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .PCLK        (PCLK),
    .reset       (reset),
    .i_load      (w_div_load),
    .i_en        (w_div_en),
    .o_half_tick (w_half_tick)
  );

  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_div_load = 1'b0;
    w_div_en   = 1'b1;
    case (r_state)
      IDLE: begin
        w_div_load = 1'b1;
        w_div_en   = 1'b0;
        if (w_accept) w_next = SHIFT;
      end
      SHIFT: if (w_half_tick && r_sclk && (r_bit_cnt == '0)) w_next = HOLD;
      HOLD:  if (w_half_tick) w_next = GAP;
      // A response still pending when the deselect time ends parks the FSM in RESP.
      GAP:   if (w_half_tick) w_next = (r_rsp_valid && !rsp_ready) ? RESP : IDLE;
      RESP: begin
        w_div_load = 1'b1;
        w_div_en   = 1'b0;
        if (w_rsp_hs) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the shift registers are reset too, because MOSI and rsp_data are taken straight from them.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      r_tx        <= '0;
      r_rx        <= '0;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_cmd_ready <= (w_next == IDLE);
      if (w_rsp_hs) r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_tx      <= cmd_data;
          r_rw      <= cmd_data[2*WIDTH];
          r_cs_n    <= 1'b0;
          r_sclk    <= 1'b0;
          r_bit_cnt <= BCW'(N_BITS - 1);
        end
        SHIFT: if (w_half_tick) begin
          if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[WIDTH-2:0], MISO};
          end else begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == '0) begin
              r_tx <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt - BCW'(1);
              r_tx      <= r_tx << 1;
            end
          end
        end
        HOLD: if (w_half_tick) begin
          r_cs_n <= 1'b1;
          if (!r_rw) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);
  assign SCLK      = r_sclk;
  assign CS_n      = r_cs_n;
  assign MOSI      = r_tx[N_BITS-1];

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: a frame-level model (bit list, frame length,
// response timing) checks a CLK_DIV=2 instance and a CLK_DIV=1 instance.
module tb_spi_master_engine;

  localparam int W  = 8;
  localparam int NB = 2*W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          sel = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [NB-1:0] cmd_data = '0;
  logic          rsp_ready = 1'b0;
  logic          miso = 1'b0;

  logic         a_cmd_ready, a_rsp_valid, a_busy, a_sclk, a_cs_n, a_mosi;
  logic         b_cmd_ready, b_rsp_valid, b_busy, b_sclk, b_cs_n, b_mosi;
  logic [W-1:0] a_rsp_data, b_rsp_data;

  spi_master_engine #(.WIDTH(W), .CLK_DIV(2)) u_dut (
    .PCLK(clk), .reset(reset),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel), .rsp_data(a_rsp_data),
    .busy(a_busy), .SCLK(a_sclk), .CS_n(a_cs_n), .MOSI(a_mosi), .MISO(miso)
  );

  spi_master_engine #(.WIDTH(W), .CLK_DIV(1)) u_dut_div1 (
    .PCLK(clk), .reset(reset),
    .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel), .rsp_data(b_rsp_data),
    .busy(b_busy), .SCLK(b_sclk), .CS_n(b_cs_n), .MOSI(b_mosi), .MISO(miso)
  );

  // Observed view of whichever instance is selected.
  logic         o_cmd_ready, o_rsp_valid, o_busy, o_sclk, o_cs_n, o_mosi;
  logic [W-1:0] o_rsp_data;
  assign o_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_sclk      = sel ? b_sclk      : a_sclk;
  assign o_cs_n      = sel ? b_cs_n      : a_cs_n;
  assign o_mosi      = sel ? b_mosi      : a_mosi;
  assign o_rsp_data  = sel ? b_rsp_data  : a_rsp_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int div();
    return sel ? 1 : 2;
  endfunction

  // Waits for cmd_ready, presents one command and confirms it was taken.
  task automatic send(input logic [NB-1:0] cmd, input bit keep_valid, input string tag);
    int t = 0;
    while (!o_cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".ready_wait"}, (t < 300), 1);
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    @(negedge clk);
    if (!keep_valid) cmd_valid = 1'b0;
    check({tag, ".cs_fall"}, o_cs_n, 0);
    check({tag, ".ready_drop"}, o_cmd_ready, 0);
  endtask

  // Called on the first sample with CS_n low. Acts as a mode-0 slave serving slv
  // and checks MOSI bits, SCLK rise timing and the CS_n low length.
  task automatic watch_frame(input logic [NB-1:0] cmd, input logic [NB-1:0] slv,
                             input int abort_rises, input string tag);
    int            idx = 0, nrise = 0, bad_t = 0, rsp_seen = 0, rdy_seen = 0;
    int            d = div();
    logic          prev = 1'b0;
    logic [NB-1:0] got = '0;
    miso = slv[NB-1];
    while (o_cs_n == 1'b0 && idx < 2000) begin
      if (o_sclk && !prev) begin
        got = {got[NB-2:0], o_mosi};
        if (idx != d + 2*d*nrise) bad_t++;
        nrise++;
        if (abort_rises > 0 && nrise == abort_rises) return;
      end else if (!o_sclk && prev && nrise < NB) begin
        miso = slv[NB-1-nrise];
      end
      if (o_rsp_valid) rsp_seen++;
      if (o_cmd_ready) rdy_seen++;
      prev = o_sclk;
      idx++;
      @(negedge clk);
    end
    check({tag, ".cs_low_len"}, idx, NB*2*d + d);
    check({tag, ".rise_count"}, nrise, NB);
    check({tag, ".mosi_bits"}, got, cmd);
    check({tag, ".rise_timing_errs"}, bad_t, 0);
    check({tag, ".rsp_in_frame"}, rsp_seen, 0);
    check({tag, ".ready_in_frame"}, rdy_seen, 0);
  endtask

  // Called on the first sample after CS_n rises. Checks the response and the
  // delay until cmd_ready returns: deselect time, or one cycle after a late handshake.
  task automatic finish_frame(input bit is_read, input logic [W-1:0] exp, input int stall,
                              input string tag, output int rdy_k);
    int d = div();
    int k = 0, viol = 0;
    int exp_k = is_read ? ((stall + 1 > d) ? stall + 1 : d) : d;
    rdy_k = -1;
    check({tag, ".rsp_valid_at_gap"}, o_rsp_valid, is_read);
    if (is_read) check({tag, ".rsp_data"}, o_rsp_data, exp);
    while (k < 200) begin
      if (o_cmd_ready) begin
        rdy_k = k;
        break;
      end
      if (is_read) begin
        if (k <= stall) begin
          if (!o_rsp_valid || o_rsp_data !== exp) viol++;
        end else if (o_rsp_valid) viol++;
        rsp_ready = (k == stall);
      end else begin
        if (o_rsp_valid) viol++;
        rsp_ready = 1'($urandom_range(0, 1));
      end
      if (o_cs_n !== 1'b1 || o_sclk !== 1'b0) viol++;
      @(negedge clk);
      k++;
    end
    rsp_ready = 1'b0;
    check({tag, ".post_frame_viol"}, viol, 0);
    check({tag, ".ready_return"}, rdy_k, exp_k);
    check({tag, ".rsp_cleared"}, o_rsp_valid, 0);
    check({tag, ".idle_busy"}, o_busy, 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] slv, c;
    int            k, viol, stall;
    bit            rd;

    #1 reset = 1'b1;
    #1;
    check("rst.sclk", o_sclk, 0);
    check("rst.cs_n", o_cs_n, 1);
    check("rst.mosi", o_mosi, 0);
    check("rst.cmd_ready", o_cmd_ready, 0);
    check("rst.rsp_valid", o_rsp_valid, 0);
    check("rst.rsp_data", o_rsp_data, 0);
    check("rst.busy", o_busy, 0);
    check("rst.div1_cs_n", b_cs_n, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.ready_after", o_cmd_ready, 1);

    // Write frame.
    slv = NB'($urandom);
    send(17'h1_A5_3C, 1'b0, "wr");
    watch_frame(17'h1_A5_3C, slv, 0, "wr");
    finish_frame(1'b0, '0, 0, "wr", k);

    // Read frame with the slave returning 0xC3.
    slv = {9'($urandom), 8'hC3};
    send(17'h0_12_00, 1'b0, "rd");
    watch_frame(17'h0_12_00, slv, 0, "rd");
    finish_frame(1'b1, 8'hC3, 0, "rd", k);

    // Response backpressure for 20 cycles.
    slv = NB'($urandom);
    c   = {1'b0, 8'($urandom), 8'h00};
    send(c, 1'b0, "bp");
    watch_frame(c, slv, 0, "bp");
    finish_frame(1'b1, slv[W-1:0], 20, "bp", k);

    // Back-to-back writes with cmd_valid held high.
    send(17'h1_3C_5A, 1'b1, "b2b_a");
    cmd_data = 17'h1_C6_E1;
    watch_frame(17'h1_3C_5A, NB'($urandom), 0, "b2b_a");
    finish_frame(1'b0, '0, 0, "b2b_a", k);
    @(negedge clk);
    check("b2b.accept_gap", (o_cs_n == 1'b0) ? k + 1 : -1, div() + 1);
    cmd_valid = 1'b0;
    watch_frame(17'h1_C6_E1, NB'($urandom), 0, "b2b_b");
    finish_frame(1'b0, '0, 0, "b2b_b", k);

    // Reset during bit 7 of a read frame, while SCLK and MOSI are both high.
    send(17'h0_5A_80, 1'b0, "midrst");
    watch_frame(17'h0_5A_80, NB'($urandom), 10, "midrst");
    check("midrst.pre_sclk", o_sclk, 1);
    check("midrst.pre_mosi", o_mosi, 1);
    #1 reset = 1'b1;
    #1;
    check("midrst.cs_n", o_cs_n, 1);
    check("midrst.sclk", o_sclk, 0);
    check("midrst.mosi", o_mosi, 0);
    check("midrst.rsp_valid", o_rsp_valid, 0);
    check("midrst.busy", o_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    viol = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_cs_n !== 1'b1 || o_rsp_valid !== 1'b0 || o_sclk !== 1'b0) viol++;
    end
    check("midrst.after_viol", viol, 0);
    check("midrst.ready", o_cmd_ready, 1);
    check("midrst.idle", o_busy, 0);

    // CLK_DIV=1 instance running the write frame.
    sel = 1'b1;
    @(negedge clk);
    send(17'h1_A5_3C, 1'b0, "div1");
    watch_frame(17'h1_A5_3C, NB'($urandom), 0, "div1");
    finish_frame(1'b0, '0, 0, "div1", k);
    sel = 1'b0;
    @(negedge clk);

    // Randomized frames on both instances.
    for (int i = 0; i < 40; i++) begin
      sel   = ($urandom_range(0, 3) == 0);
      c     = NB'($urandom);
      slv   = NB'($urandom);
      stall = $urandom_range(0, 6);
      rd    = !c[NB-1];
      @(negedge clk);
      send(c, 1'b0, "rnd");
      watch_frame(c, slv, 0, "rnd");
      finish_frame(rd, slv[W-1:0], stall, "rnd", k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
